// File: rtl/spr_dma_pkg.sv
// Shared types and constants for the sprite DMA block.
// States, trigger and OAM port addresses, and the fixed transfer length.
package spr_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [15:0] TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAM_ADDR  = 16'h2004;
    localparam int          BYTE_CNT  = 256;
    localparam logic [7:0]  LAST_IDX  = 8'(BYTE_CNT - 1);

endpackage

// File: rtl/spr_dma.sv
// Sprite DMA: a CPU write to the trigger address copies one 256-byte page to the OAM port.
// Latency: 513 bus-owning cycles from the edge after the trigger; no backpressure, the CPU is halted.
module spr_dma
    import spr_dma_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] cpumc_a_in,
    input  logic [7:0]  cpumc_din_in,
    input  logic [7:0]  cpumc_dout_in,
    input  logic        cpu_r_nw_in,
    output logic        active_out,
    output logic [15:0] cpumc_a_out,
    output logic [7:0]  cpumc_d_out,
    output logic        cpumc_r_nw_out
);

    state_t     state_q, state_d;
    logic [7:0] n_q, n_d;
    logic [7:0] p_q, p_d;
    logic [7:0] d_q, d_d;
    logic       trig;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            n_q     <= 8'h00;
            p_q     <= 8'h00;
            d_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            p_q     <= p_d;
            d_q     <= d_d;
        end
    end

    // Triggers are only honoured from IDLE, so a write landing on the final WRITE edge is dropped.
    assign trig = (cpumc_a_in == TRIG_ADDR) && !cpu_r_nw_in;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        p_d     = p_q;
        d_d     = d_q;
        unique case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    p_d     = cpumc_din_in;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                n_d     = 8'h00;
                state_d = ST_READ;
            end
            ST_READ: begin
                d_d     = cpumc_dout_in;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (n_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    n_d     = n_q + 8'd1;
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode registered state only, so reset forces them idle without waiting for a clock.
    always_comb begin
        active_out     = 1'b0;
        cpumc_a_out    = 16'h0000;
        cpumc_d_out    = 8'h00;
        cpumc_r_nw_out = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
                active_out = 1'b1;
            end
            ST_READ: begin
                active_out  = 1'b1;
                cpumc_a_out = {p_q, n_q};
            end
            ST_WRITE: begin
                active_out     = 1'b1;
                cpumc_a_out    = OAM_ADDR;
                cpumc_d_out    = d_q;
                cpumc_r_nw_out = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_spr_dma.sv
// Self-checking bench for spr_dma: idle vector table, scoreboarded page transfers, retrigger/reset corners.
module tb_spr_dma;
    import spr_dma_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] cpumc_a_in;
    logic [7:0]  cpumc_din_in;
    logic [7:0]  cpumc_dout_in;
    logic        cpu_r_nw_in;
    logic        active_out;
    logic [15:0] cpumc_a_out;
    logic [7:0]  cpumc_d_out;
    logic        cpumc_r_nw_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];
    logic        prev_active = 1'b0;

    always #10 clk_in = ~clk_in;

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return (a[15:8] == 8'hff) ? ~a[7:0] : (a[7:0] ^ 8'h5a);
    endfunction

    assign cpumc_dout_in = mem_rd(cpumc_a_out);

    spr_dma dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .cpumc_a_in    (cpumc_a_in),
        .cpumc_din_in  (cpumc_din_in),
        .cpumc_dout_in (cpumc_dout_in),
        .cpu_r_nw_in   (cpu_r_nw_in),
        .active_out    (active_out),
        .cpumc_a_out   (cpumc_a_out),
        .cpumc_d_out   (cpumc_d_out),
        .cpumc_r_nw_out(cpumc_r_nw_out)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  din;
        logic        rnw;
        logic        exp_active;
        logic [15:0] exp_a;
        logic [7:0]  exp_d;
        logic        exp_rnw;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bus_snap();
        return {6'd0, active_out, cpumc_a_out, cpumc_d_out, cpumc_r_nw_out};
    endfunction

    localparam logic [31:0] IDLE_SNAP = {6'd0, 1'b0, 16'h0000, 8'h00, 1'b1};

    task automatic bus_idle();
        cpumc_a_in   = 16'h0000;
        cpumc_din_in = 8'h00;
        cpu_r_nw_in  = 1'b1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpumc_a_in   = a;
        cpumc_din_in = d;
        cpu_r_nw_in  = 1'b0;
    endtask

    // Advance to the next falling edge and score any DMA bus cycle seen there.
    task automatic step();
        logic [15:0] ea;
        logic [7:0]  ed;
        @(negedge clk_in);
        if (active_out && !cpumc_r_nw_out) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", {16'h0, cpumc_a_out}, 32'hffff_ffff);
            end else begin
                ed = wr_q.pop_front();
                chk("write_addr", {16'h0, cpumc_a_out}, {16'h0, OAM_ADDR});
                chk("write_data", {24'h0, cpumc_d_out}, {24'h0, ed});
            end
        end else if (active_out && cpumc_r_nw_out && prev_active) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_read", {16'h0, cpumc_a_out}, 32'hffff_ffff);
            end else begin
                ea = rd_q.pop_front();
                chk("read_addr", {16'h0, cpumc_a_out}, {16'h0, ea});
            end
        end
        prev_active = active_out;
    endtask

    task automatic run_xfer(input logic [7:0] page, input int retrig_at,
                            input int rst_at, input bit end_trig);
        int  cyc;
        bit  quiet;
        cpu_wr(TRIG_ADDR, page);
        for (int i = 0; i < BYTE_CNT; i++) begin
            rd_q.push_back({page, 8'(i)});
            wr_q.push_back(mem_rd({page, 8'(i)}));
        end
        cyc = 0;
        while (cyc < 2000) begin
            step();
            if (cyc == 0) bus_idle();
            if (!active_out) break;
            cyc++;
            if (cyc == 1) chk("cyc1_start", bus_snap(), {6'd0, 1'b1, 16'h0000, 8'h00, 1'b1});
            if (cyc == 2) chk("cyc2_read", {15'd0, cpumc_a_out, cpumc_r_nw_out}, {15'd0, page, 8'h00, 1'b1});
            if (cyc == 3) chk("cyc3_write", {7'd0, cpumc_a_out, cpumc_d_out, cpumc_r_nw_out},
                              {7'd0, OAM_ADDR, mem_rd({page, 8'h00}), 1'b0});
            if (cyc == 513) chk("cyc513_write", {15'd0, cpumc_a_out, cpumc_r_nw_out}, {15'd0, OAM_ADDR, 1'b0});
            if (retrig_at != 0 && cyc == retrig_at) cpu_wr(TRIG_ADDR, 8'h07);
            if (retrig_at != 0 && cyc == retrig_at + 1) bus_idle();
            if (end_trig && cyc == 513) cpu_wr(TRIG_ADDR, 8'h33);
            if (rst_at != 0 && cyc == rst_at) begin
                #2 rst_in = 1'b1;
                #1 chk("async_rst_idle", bus_snap(), IDLE_SNAP);
                break;
            end
        end
        bus_idle();
        if (rst_at != 0) begin
            chk("rst_writes_left", wr_q.size(), 32'd157);
            chk("rst_reads_left", rd_q.size(), 32'd156);
            rd_q.delete();
            wr_q.delete();
            step();
            step();
            rst_in = 1'b0;
            quiet = 1'b1;
            for (int i = 0; i < 20; i++) begin
                step();
                if (bus_snap() !== IDLE_SNAP) quiet = 1'b0;
            end
            chk("post_rst_quiet", {31'd0, quiet}, 32'd1);
        end else begin
            chk("active_cycles", cyc, 32'd513);
            chk("cyc514_idle", bus_snap(), IDLE_SNAP);
            chk("writes_drained", wr_q.size(), 32'd0);
            chk("reads_drained", rd_q.size(), 32'd0);
            quiet = 1'b1;
            for (int i = 0; i < 4; i++) begin
                step();
                if (active_out !== 1'b0) quiet = 1'b0;
            end
            chk("stays_idle", {31'd0, quiet}, 32'd1);
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{a: 16'h4014, din: 8'h02, rnw: 1'b1, exp_active: 1'b0, exp_a: 16'h0, exp_d: 8'h0, exp_rnw: 1'b1};
        vecs[1] = '{a: 16'h4015, din: 8'h03, rnw: 1'b0, exp_active: 1'b0, exp_a: 16'h0, exp_d: 8'h0, exp_rnw: 1'b1};
        vecs[2] = '{a: 16'h4013, din: 8'h02, rnw: 1'b0, exp_active: 1'b0, exp_a: 16'h0, exp_d: 8'h0, exp_rnw: 1'b1};
        vecs[3] = '{a: 16'h0014, din: 8'h02, rnw: 1'b0, exp_active: 1'b0, exp_a: 16'h0, exp_d: 8'h0, exp_rnw: 1'b1};
        vecs[4] = '{a: 16'hc014, din: 8'h02, rnw: 1'b0, exp_active: 1'b0, exp_a: 16'h0, exp_d: 8'h0, exp_rnw: 1'b1};

        rst_in = 1'b1;
        bus_idle();
        step();
        step();
        chk("reset_outputs", bus_snap(), IDLE_SNAP);
        rst_in = 1'b0;
        step();
        chk("idle_after_reset", bus_snap(), IDLE_SNAP);

        foreach (vecs[i]) begin
            cpumc_a_in   = vecs[i].a;
            cpumc_din_in = vecs[i].din;
            cpu_r_nw_in  = vecs[i].rnw;
            step();
            bus_idle();
            step();
            chk($sformatf("no_trigger_%0d", i), bus_snap(),
                {6'd0, vecs[i].exp_active, vecs[i].exp_a, vecs[i].exp_d, vecs[i].exp_rnw});
        end

        run_xfer(8'h02, 0, 0, 1'b0);
        run_xfer(8'h01, 100, 0, 1'b0);
        run_xfer(8'h04, 0, 200, 1'b0);
        run_xfer(8'hff, 0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spr_dma.md
SPR_DMA -- requirements
Module: spr_dma

Interface
REQ-001 clk_in  input  1  system clock (50MHz); all state updates on rising edge.
REQ-002 rst_in  input  1  reset, asynchronous, active-high.
REQ-003 cpumc_a_in  input  16  CPU bus address, used to snoop writes.
REQ-004 cpumc_din_in  input  8  CPU bus write data, used to snoop the page number.
REQ-005 cpumc_dout_in  input  8  memory read data for the address currently driven on cpumc_a_out; valid in the same cycle.
REQ-006 cpu_r_nw_in  input  1  CPU read(1)/write(0) strobe.
REQ-007 active_out  output  1  high while a transfer owns the bus; the system uses it to halt the CPU and select the DMA bus outputs.
REQ-008 cpumc_a_out  output  16  DMA bus address.
REQ-009 cpumc_d_out  output  8  DMA bus write data.
REQ-010 cpumc_r_nw_out  output  1  DMA bus read(1)/write(0).

Function
REQ-011 Trigger: rising edge where !active_out, cpu_r_nw_in=0 and cpumc_a_in=16'h4014 SHALL latch the page register P=cpumc_din_in and move IDLE->START.
REQ-012 States SHALL be IDLE, START, READ and WRITE, with an 8-bit byte counter N.
REQ-013 IDLE SHALL drive active_out=0, cpumc_a_out=16'h0000, cpumc_d_out=8'h00 and cpumc_r_nw_out=1.
REQ-014 START lasts exactly 1 cycle (lets the CPU write cycle retire), SHALL drive active_out=1, a_out=16'h0000 and r_nw_out=1, clears N to 0 and goes to READ.
REQ-015 READ lasts 1 cycle and SHALL drive active_out=1, a_out={P,N} and r_nw_out=1; on exit the data register D=cpumc_dout_in.
REQ-016 WRITE lasts 1 cycle and SHALL drive active_out=1, a_out=16'h2004 (OAM data port), d_out=D and r_nw_out=0.
REQ-017 WRITE exit: if N=8'hff the block SHALL go to IDLE; otherwise N=N+1 (8-bit) and the block goes to READ.
REQ-018 Exactly 256 reads ({P,00}..{P,ff}) and 256 writes to 16'h2004 SHALL occur in ascending order, with no wrap into page P+1.
REQ-019 Latency: active_out high for exactly 513 consecutive cycles (1 START + 256 x 2), beginning on the cycle after the trigger edge.
REQ-020 Writes to 16'h4014 while active_out=1 SHALL be ignored; P and N are unchanged.
REQ-021 Reads of 16'h4014 (cpu_r_nw_in=1) and writes to any other address SHALL NOT trigger.
REQ-022 A trigger on the same edge that WRITE(N=ff) completes SHALL be ignored (active_out still high); IDLE is entered.
REQ-023 All outputs SHALL be decoded from registered state only, with no combinational path from the inputs; cpumc_dout_in reaches the outputs only through D.
REQ-024 P=8'hff SHALL read 16'hff00..16'hffff, with no special casing.

Reset
REQ-025 rst_in high SHALL immediately force IDLE, N=0, P=0 and D=0, with outputs as in REQ-013, including when asserted mid-transfer.
REQ-026 After reset deasserts mid-transfer, no remaining bytes SHALL be transferred; a new trigger is required.

Structure
REQ-027 The shared package SHALL hold the state enumeration and the constants for the trigger address 16'h4014, the OAM port 16'h2004 and the byte count 256.
REQ-028 The block SHALL be a single module with no sub-modules; the counter and FSM are inline.

Verification
REQ-029 Write 8'h02 to 16'h4014 with memory 16'h0200+i = i^8'h5a -> 513 active cycles, 256 writes to 16'h2004 with data i^8'h5a in order i=0..255.
REQ-030 Cycle check, same stimulus -> cycle 1 START; cycle 2 a_out=16'h0200, r_nw=1; cycle 3 a_out=16'h2004, r_nw=0; cycle 513 is WRITE of byte ff; cycle 514 IDLE.
REQ-031 Read of 16'h4014, and write of 8'h03 to 16'h4015 -> active_out stays 0 and outputs remain at their IDLE values.
REQ-032 Trigger with page 8'h01, then write 8'h07 to 16'h4014 at cycle 100 -> transfer continues from 16'h01xx, with no restart and a total of 513 active cycles.
REQ-033 Assert rst_in asynchronously (between clock edges) at cycle 200 of a transfer -> outputs reach their IDLE values before the next edge; after release no bus activity until a new trigger.
REQ-034 Page 8'hff with memory 16'hff00+i = ~i -> the last read address is 16'hffff, no access to 16'h00xx, and data ~i is written.
